// File: rtl/chess_move_controller_if.sv
// Layout memory bus between chess_move_controller (master) and the
// 64-square layout store (slave). RdData is valid the cycle after RdEn.
interface chess_move_controller_if #(
    parameter int IDX_W   = 6,
    parameter int PIECE_W = 4
);
    logic               RdEn;
    logic [IDX_W-1:0]   RdAddr;
    logic [PIECE_W-1:0] RdData;
    logic               WrEn;
    logic [IDX_W-1:0]   WrAddr;
    logic [PIECE_W-1:0] WrData;

    modport master (
        output RdEn, RdAddr, WrEn, WrAddr, WrData,
        input  RdData
    );

    modport slave (
        input  RdEn, RdAddr, WrEn, WrAddr, WrData,
        output RdData
    );
endinterface

// File: rtl/chess_move_controller.sv
// Move sequencer for the 64-square layout store: source select, destination
// select, then an atomic two-write commit (destination, then clear source).
// Owns the side-to-move flag and checks colour ownership only.
// Optional macro CAPTURE_COUNT_EN enables per-side saturating capture counters;
// when undefined, WhiteCaptures/BlackCaptures are tied to zero.
module chess_move_controller #(
    parameter int IDX_W   = 6,
    parameter int PIECE_W = 4,
    parameter int CNT_W   = 4
) (
    input  logic                 OutClock,
    input  logic                 resetApp,
    input  logic                 SelectKey,
    input  logic                 CancelKey,
    input  logic [IDX_W-1:0]     CursorIdx,
    input  logic                 GameActive,
    chess_move_controller_if.master layoutBus,
    output logic                 Turn,
    output logic                 SrcValid,
    output logic [IDX_W-1:0]     SrcIdx,
    output logic                 MoveDone,
    output logic                 MoveReject,
    output logic [CNT_W-1:0]     WhiteCaptures,
    output logic [CNT_W-1:0]     BlackCaptures
);

    typedef enum logic [3:0] {
        IDLE, RD_SRC, CHK_SRC, SRC_HELD, RD_DST, CHK_DST, WR_DST, WR_SRC, DONE
    } stateT;

    stateT state, nextState;

    logic               selPrev, canPrev;
    logic               selEvt, canEvt;
    logic [IDX_W-1:0]   candIdx;
    logic [PIECE_W-1:0] heldPiece;
    logic               pieceNonEmpty, pieceOwn;
    logic               rejectNow, latchCand, takeSrc, heldNext;

    // Press events: released on the previous tick, pressed on this one
    assign selEvt        = selPrev & ~SelectKey;
    assign canEvt        = canPrev & ~CancelKey;
    assign pieceNonEmpty = |layoutBus.RdData;
    assign pieceOwn      = pieceNonEmpty && (layoutBus.RdData[PIECE_W-1] == Turn);

    // State register
    always_ff @(posedge OutClock or posedge resetApp) begin
        if (resetApp) state <= IDLE;
        else          state <= nextState;
    end

    // Next-state decode and Moore bus strobes
    always_comb begin
        nextState         = state;
        rejectNow         = 1'b0;
        layoutBus.RdEn    = 1'b0;
        layoutBus.RdAddr  = '0;
        layoutBus.WrEn    = 1'b0;
        layoutBus.WrAddr  = '0;
        layoutBus.WrData  = '0;
        MoveDone          = 1'b0;
        unique case (state)
            IDLE:     if (GameActive && selEvt && !canEvt) nextState = RD_SRC;
            RD_SRC: begin
                layoutBus.RdEn   = 1'b1;
                layoutBus.RdAddr = candIdx;
                nextState        = GameActive ? CHK_SRC : IDLE;
            end
            CHK_SRC: begin
                if (GameActive && pieceOwn) nextState = SRC_HELD;
                else                        nextState = IDLE;
                rejectNow = GameActive && !pieceOwn;
            end
            SRC_HELD: begin
                if (!GameActive || canEvt) nextState = IDLE;
                else if (selEvt)           nextState = RD_DST;
            end
            RD_DST: begin
                layoutBus.RdEn   = 1'b1;
                layoutBus.RdAddr = candIdx;
                nextState        = GameActive ? CHK_DST : IDLE;
            end
            CHK_DST: begin
                if (!GameActive || candIdx == SrcIdx) nextState = IDLE;
                else if (pieceOwn)                    nextState = SRC_HELD;
                else                                  nextState = WR_DST;
            end
            WR_DST: begin
                layoutBus.WrEn   = 1'b1;
                layoutBus.WrAddr = candIdx;
                layoutBus.WrData = heldPiece;
                nextState        = WR_SRC;
            end
            WR_SRC: begin
                layoutBus.WrEn   = 1'b1;
                layoutBus.WrAddr = SrcIdx;
                nextState        = DONE;
            end
            DONE: begin
                MoveDone  = 1'b1;
                nextState = IDLE;
            end
            default:  nextState = IDLE;
        endcase
    end

    assign latchCand = ((state == IDLE) && (nextState == RD_SRC)) ||
                       ((state == SRC_HELD) && (nextState == RD_DST));
    assign takeSrc   = ((state == CHK_SRC) || (state == CHK_DST)) && (nextState == SRC_HELD);
    assign heldNext  = nextState inside {SRC_HELD, RD_DST, CHK_DST, WR_DST, WR_SRC};

    // Key history, held source, candidate square, turn and reject pulse
    always_ff @(posedge OutClock or posedge resetApp) begin
        if (resetApp) begin
            selPrev    <= 1'b1;
            canPrev    <= 1'b1;
            candIdx    <= '0;
            SrcIdx     <= '0;
            heldPiece  <= '0;
            SrcValid   <= 1'b0;
            MoveReject <= 1'b0;
            Turn       <= 1'b0;
        end else begin
            selPrev    <= SelectKey;
            canPrev    <= CancelKey;
            SrcValid   <= heldNext;
            MoveReject <= rejectNow;
            if (latchCand) candIdx <= CursorIdx;
            if (takeSrc) begin
                SrcIdx    <= candIdx;
                heldPiece <= layoutBus.RdData;
            end
            if (state == DONE) Turn <= ~Turn;
        end
    end

`ifdef CAPTURE_COUNT_EN
    logic captureFlag;

    // Capture flag from destination check; mover's counter bumps in DONE (Turn not yet toggled)
    always_ff @(posedge OutClock or posedge resetApp) begin
        if (resetApp) begin
            captureFlag   <= 1'b0;
            WhiteCaptures <= '0;
            BlackCaptures <= '0;
        end else begin
            if ((state == CHK_DST) && (nextState == WR_DST)) captureFlag <= pieceNonEmpty;
            if ((state == DONE) && captureFlag) begin
                if (!Turn && (WhiteCaptures != '1)) WhiteCaptures <= WhiteCaptures + CNT_W'(1);
                if ( Turn && (BlackCaptures != '1)) BlackCaptures <= BlackCaptures + CNT_W'(1);
            end
        end
    end
`else
    assign WhiteCaptures = '0;
    assign BlackCaptures = '0;
`endif

endmodule

// File: tb/tb_chess_move_controller.sv
// Directed bench for chess_move_controller with a behavioural layout store
// and a scoreboard of expected layout writes.
module tb_chess_move_controller;
    localparam int IDX_W   = 6;
    localparam int PIECE_W = 4;
    localparam int CNT_W   = 4;

`ifdef CAPTURE_COUNT_EN
    localparam logic [CNT_W-1:0] EXP_BCAP = 4'd1;
`else
    localparam logic [CNT_W-1:0] EXP_BCAP = 4'd0;
`endif

    logic               OutClock = 1'b0;
    logic               resetApp, SelectKey, CancelKey, GameActive;
    logic [IDX_W-1:0]   CursorIdx;
    logic               Turn, SrcValid, MoveDone, MoveReject;
    logic [IDX_W-1:0]   SrcIdx;
    logic [CNT_W-1:0]   WhiteCaptures, BlackCaptures;

    chess_move_controller_if #(.IDX_W(IDX_W), .PIECE_W(PIECE_W)) bus ();

    chess_move_controller #(.IDX_W(IDX_W), .PIECE_W(PIECE_W), .CNT_W(CNT_W)) dut (
        .OutClock      (OutClock),
        .resetApp      (resetApp),
        .SelectKey     (SelectKey),
        .CancelKey     (CancelKey),
        .CursorIdx     (CursorIdx),
        .GameActive    (GameActive),
        .layoutBus     (bus.master),
        .Turn          (Turn),
        .SrcValid      (SrcValid),
        .SrcIdx        (SrcIdx),
        .MoveDone      (MoveDone),
        .MoveReject    (MoveReject),
        .WhiteCaptures (WhiteCaptures),
        .BlackCaptures (BlackCaptures)
    );

    always #5 OutClock = ~OutClock;

    logic [PIECE_W-1:0] mem [64];
    int nTests = 0;
    int nFail  = 0;

    typedef struct {
        logic [IDX_W-1:0]   addr;
        logic [PIECE_W-1:0] data;
    } wrT;
    wrT wq[$];

    // Layout store model: registered read, write on strobe
    always @(posedge OutClock) begin
        if (resetApp) bus.RdData <= '0;
        else if (bus.RdEn) bus.RdData <= mem[bus.RdAddr];
        if (!resetApp && bus.WrEn) mem[bus.WrAddr] = bus.WrData;
    end

    // Scoreboard: every observed write must match the next expected one
    always @(negedge OutClock) begin
        if (!resetApp && bus.WrEn) begin
            nTests++;
            assert (wq.size() > 0) else begin
                nFail++;
                $error("FAIL unexpected_write: got addr %0d data %0h, expected no write", bus.WrAddr, bus.WrData);
            end
            if (wq.size() > 0) begin
                wrT e;
                e = wq.pop_front();
                nTests++;
                assert ({bus.WrAddr, bus.WrData} === {e.addr, e.data}) else begin
                    nFail++;
                    $error("FAIL write: got addr %0d data %0h, expected addr %0d data %0h",
                           bus.WrAddr, bus.WrData, e.addr, e.data);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge OutClock);
        #1;
    endtask

    task automatic pressSel(input logic [IDX_W-1:0] idx);
        CursorIdx = idx;
        SelectKey = 1'b0;
        tick();
        SelectKey = 1'b1;
    endtask

    task automatic expectWrite(input logic [IDX_W-1:0] a, input logic [PIECE_W-1:0] d);
        wrT e;
        e.addr = a;
        e.data = d;
        wq.push_back(e);
    endtask

    // Called right after the destination press; counts ticks until MoveDone
    task automatic waitDone(input string tag);
        int lat;
        lat = 1;
        while (!MoveDone && lat < 12) begin
            tick();
            lat++;
        end
        chk(tag, lat, 5);
    endtask

    initial begin
        SelectKey  = 1'b1;
        CancelKey  = 1'b1;
        GameActive = 1'b1;
        CursorIdx  = '0;
        resetApp   = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[12] = 4'h1;
        mem[52] = 4'h1;
        mem[51] = 4'hA;
        mem[35] = 4'h1;
        tick();
        tick();
        resetApp = 1'b0;
        tick();

        chk("rst_turn", Turn, 0);
        chk("rst_srcvalid", SrcValid, 0);
        chk("rst_srcidx", SrcIdx, 0);
        chk("rst_rden", bus.RdEn, 0);
        chk("rst_wren", bus.WrEn, 0);
        chk("rst_done", MoveDone, 0);
        chk("rst_reject", MoveReject, 0);
        chk("rst_wcap", WhiteCaptures, 0);
        chk("rst_bcap", BlackCaptures, 0);

        // White picks up piece at 12
        pressSel(12);
        chk("src_rden", bus.RdEn, 1);
        chk("src_rdaddr", bus.RdAddr, 12);
        tick();
        tick();
        chk("src_valid", SrcValid, 1);
        chk("src_idx", SrcIdx, 12);
        chk("src_turn", Turn, 0);

        // Move 12 -> 28 (empty)
        expectWrite(28, 4'h1);
        expectWrite(12, 4'h0);
        pressSel(28);
        chk("dst_rden", bus.RdEn, 1);
        chk("dst_rdaddr", bus.RdAddr, 28);
        waitDone("move1_latency");
        tick();
        chk("move1_turn", Turn, 1);
        chk("move1_srcvalid", SrcValid, 0);
        chk("move1_done_pulse", MoveDone, 0);

        // Black tries to take a white piece as source
        pressSel(52);
        tick();
        tick();
        chk("rej_pulse", MoveReject, 1);
        chk("rej_srcvalid", SrcValid, 0);
        tick();
        chk("rej_pulse_end", MoveReject, 0);

        // Black 51 captures white at 35
        pressSel(51);
        tick();
        tick();
        chk("cap_srcvalid", SrcValid, 1);
        chk("cap_srcidx", SrcIdx, 51);
        expectWrite(35, 4'hA);
        expectWrite(51, 4'h0);
        pressSel(35);
        waitDone("cap_latency");
        tick();
        chk("cap_turn", Turn, 0);
        chk("cap_bcap", BlackCaptures, EXP_BCAP);
        chk("cap_wcap", WhiteCaptures, 0);

        // Select + Cancel in same tick while holding 28: cancel wins
        pressSel(28);
        tick();
        tick();
        chk("hold28_valid", SrcValid, 1);
        CursorIdx = 36;
        SelectKey = 1'b0;
        CancelKey = 1'b0;
        tick();
        SelectKey = 1'b1;
        CancelKey = 1'b1;
        chk("selcan_srcvalid", SrcValid, 0);
        chk("selcan_rden", bus.RdEn, 0);
        tick();
        chk("selcan_rden2", bus.RdEn, 0);

        // Held key gives one event only
        CursorIdx = 28;
        SelectKey = 1'b0;
        tick();
        chk("held_rden", bus.RdEn, 1);
        tick();
        tick();
        chk("held_valid", SrcValid, 1);
        tick();
        chk("held_no_second", bus.RdEn, 0);
        chk("held_still_valid", SrcValid, 1);
        SelectKey = 1'b1;
        tick();

        // GameActive drop while holding aborts; presses ignored while inactive
        GameActive = 1'b0;
        tick();
        chk("abort_srcvalid", SrcValid, 0);
        pressSel(28);
        chk("inactive_rden", bus.RdEn, 0);
        GameActive = 1'b1;
        tick();

        // Destination equals source: silent deselect
        pressSel(28);
        tick();
        tick();
        chk("same_hold", SrcValid, 1);
        pressSel(28);
        tick();
        tick();
        chk("same_srcvalid", SrcValid, 0);
        chk("same_wren", bus.WrEn, 0);
        chk("same_done", MoveDone, 0);

        // White 28 -> 20
        pressSel(28);
        tick();
        tick();
        expectWrite(20, 4'h1);
        expectWrite(28, 4'h0);
        pressSel(20);
        waitDone("move3_latency");
        tick();
        chk("move3_turn", Turn, 1);

        // Black 35 -> 43, reset lands in WR_DST
        pressSel(35);
        tick();
        tick();
        chk("rst_seq_hold", SrcValid, 1);
        pressSel(43);
        tick();
        tick();
        chk("wrdst_wren", bus.WrEn, 1);
        chk("wrdst_addr", bus.WrAddr, 43);
        resetApp = 1'b1;
        #1;
        chk("midrst_turn", Turn, 0);
        chk("midrst_srcvalid", SrcValid, 0);
        chk("midrst_wren", bus.WrEn, 0);
        chk("midrst_rden", bus.RdEn, 0);
        chk("midrst_bcap", BlackCaptures, 0);
        tick();
        resetApp = 1'b0;
        tick();
        tick();
        chk("post_rst_wren", bus.WrEn, 0);
        chk("scoreboard_empty", wq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
